// File: rtl/empty_ptr_alloc.sv
// Free-address allocator for the data table: offers one free address at a time,
// recycling released addresses through a FIFO and handing out never-used ones from a counter.
module empty_ptr_alloc #(
   parameter int A_WIDTH = 10,
   parameter int FIFO_AW = A_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   output logic [A_WIDTH-1:0] empty_addr_o,
   output logic               empty_addr_val_o,
   input  logic               empty_addr_rd_ack_i,
   input  logic [A_WIDTH-1:0] add_addr_i,
   input  logic               add_addr_val_i,
   output logic [A_WIDTH:0]   free_cnt_o,
   output logic               err_overflow_o,
   output logic               err_underflow_o
);

   localparam int FIFO_SIZE = 2 ** FIFO_AW;
   localparam logic [A_WIDTH:0] DEPTH_CNT = {1'b1, {A_WIDTH{1'b0}}};

   typedef enum logic [1:0] {SRC_NONE, SRC_FIFO, SRC_FRESH, SRC_BYPASS} src_e;

   logic [A_WIDTH-1:0] fifo_mem [FIFO_SIZE];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [FIFO_AW:0]   fifo_cnt;
   logic [A_WIDTH:0]   fresh;

   logic ack_ok, rel_ok, load, push, pop, overflow, underflow;
   src_e src;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
      src       = SRC_NONE;
      ack_ok    = empty_addr_rd_ack_i & empty_addr_val_o;
      underflow = empty_addr_rd_ack_i & ~empty_addr_val_o;
      overflow  = add_addr_val_i & (free_cnt_o == DEPTH_CNT) & ~ack_ok;
      rel_ok    = add_addr_val_i & ~overflow;
      load      = ~empty_addr_val_o | ack_ok;
      if (load) begin
         if (fifo_cnt != '0)          src = SRC_FIFO;
         else if (fresh < DEPTH_CNT)  src = SRC_FRESH;
         else if (rel_ok)             src = SRC_BYPASS;
      end
      pop  = (src == SRC_FIFO);
      push = rel_ok & (src != SRC_BYPASS);
   end

   // NOTE: the FIFO storage has no reset; the pointers and count alone define its contents.
   always_ff @(posedge clk_i) begin
      if (push && !clear_i) fifo_mem[wr_ptr] <= add_addr_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         empty_addr_o     <= '0;
         empty_addr_val_o <= 1'b0;
         fresh            <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         fifo_cnt         <= '0;
         free_cnt_o       <= DEPTH_CNT;
         err_overflow_o   <= 1'b0;
         err_underflow_o  <= 1'b0;
      end else if (clear_i) begin
         empty_addr_o     <= '0;
         empty_addr_val_o <= 1'b0;
         fresh            <= '0;
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         fifo_cnt         <= '0;
         free_cnt_o       <= DEPTH_CNT;
         err_overflow_o   <= 1'b0;
         err_underflow_o  <= 1'b0;
      end else begin
         // Address stays frozen while valid and unacknowledged; only a load changes it.
         if (load) begin
            unique case (src)
               SRC_FIFO: begin
                  empty_addr_o     <= fifo_mem[rd_ptr];
                  empty_addr_val_o <= 1'b1;
               end
               SRC_FRESH: begin
                  empty_addr_o     <= fresh[A_WIDTH-1:0];
                  empty_addr_val_o <= 1'b1;
                  fresh            <= fresh + (A_WIDTH+1)'(1);
               end
               SRC_BYPASS: begin
                  empty_addr_o     <= add_addr_i;
                  empty_addr_val_o <= 1'b1;
               end
               default: empty_addr_val_o <= 1'b0;
            endcase
         end

         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);

         unique case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase

         unique case ({rel_ok, ack_ok})
            2'b10:   free_cnt_o <= free_cnt_o + (A_WIDTH+1)'(1);
            2'b01:   free_cnt_o <= free_cnt_o - (A_WIDTH+1)'(1);
            default: free_cnt_o <= free_cnt_o;
         endcase

         if (overflow)  err_overflow_o  <= 1'b1;
         if (underflow) err_underflow_o <= 1'b1;
      end
   end

endmodule

// File: doc/empty_ptr_alloc.md
Name: empty_ptr_alloc

Overview:
Free-address allocator for the data table. It offers one free data-RAM address at a time to the insert engine, which uses it and then acknowledges it. Addresses released by the delete engine are recycled through an internal FIFO. Addresses never yet allocated come from a "fresh" counter, so no init sweep is needed after reset or clear.

Parameters:
A_WIDTH, 10, data-table address width; DEPTH = 2**A_WIDTH addresses managed.
FIFO_AW, A_WIDTH, recycle FIFO address width; FIFO holds up to 2**FIFO_AW entries (must be >= DEPTH).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
clear_i  in  1  sync re-init: all DEPTH addresses free again
empty_addr_o  out  A_WIDTH  offered free address; drives insert engine empty_addr_i
empty_addr_val_o  out  1  offered address valid; drives insert engine empty_addr_val_i
empty_addr_rd_ack_i  in  1  single-cycle pop of offered address, from insert engine
add_addr_i  in  A_WIDTH  address being released
add_addr_val_i  in  1  single-cycle release strobe, from delete engine
free_cnt_o  out  A_WIDTH+1  number of free addresses, 0..DEPTH
err_overflow_o  out  1  sticky: release dropped because free_cnt was DEPTH
err_underflow_o  out  1  sticky: ack received while empty_addr_val_o=0

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_i.
- Outputs in reset: empty_addr_o=0, empty_addr_val_o=0, free_cnt_o=DEPTH, both err=0.
- Internal state cleared by reset: slot empty, fresh=0, FIFO empty.
- Offer slot: registered empty_addr_o/empty_addr_val_o.
  - Once val=1, addr stays stable until the cycle the ack is sampled, regardless of releases. The insert engine relies on this across its multi-cycle writes.
- Slot load occurs at a clock edge when the slot is empty or an ack is sampled. Source priority:
  1. FIFO head, if the FIFO is non-empty; the FIFO is popped.
  2. Fresh counter, if fresh < DEPTH; fresh increments.
  3. add_addr_i bypass, if add_addr_val_i=1; that address is not pushed to the FIFO.
  4. None of the above: val goes to 0.
- Latency:
  - First offer (addr 0) appears 1 cycle after reset release.
  - Ack at edge N gives the next offer at N+1, so back-to-back acks are sustained.
  - With the allocator exhausted, a release at edge N is offered at N+1 via the bypass.
- Release handling: if not consumed by the bypass and not an overflow, add_addr_i is pushed into the FIFO tail the same edge. FIFO pointers wrap modulo 2**FIFO_AW.
- Simultaneous ack and release:
  - Both are processed.
  - The FIFO push and the slot reload from the FIFO head in the same edge are legal; the pop takes the old head.
  - With an empty FIFO and fresh exhausted, the bypass takes the release.
- free_cnt_o (registered) = slot_val + fifo_count + (DEPTH - fresh). Update rules:
  - +1 on an accepted release.
  - -1 on an accepted ack.
  - Unchanged when both happen together.
- Overflow: a release with free_cnt_o==DEPTH and no same-cycle ack is dropped; err_overflow_o is set.
- Underflow: an ack with val=0 is ignored (no state change); err_underflow_o is set.
- Error flags are sticky until reset or clear_i.
- clear_i: behaves as reset, synchronously, and overrides ack and release in the same cycle. val=0 in the cycle after clear; the addr 0 offer follows one cycle later.
- No duplicate-release detection; the caller guarantees each address is released once.

Test Plan:
- Reset release (A_WIDTH=3) -> cycle 1: val=1, addr=0, free_cnt=8. Acks on 3 consecutive cycles -> addr 1,2,3 on successive cycles, free_cnt=5.
- Exhaustion (A_WIDTH=3): 8 acks -> val=0, free_cnt=0. Release 5 at edge N -> val=1, addr=5 at N+1, free_cnt=1.
- Recycle priority: ack 0..3 (slot holds 4), release 2 then 0, hold addr 4 stable for 10 cycles, ack -> offers 2, then 0, then 5.
- Simultaneous: with slot=4 and FIFO={2}, ack plus release 7 same cycle -> offer 2, FIFO={7}, free_cnt unchanged.
- Errors: after reset, release 3 -> err_overflow=1, free_cnt=8. Exhaust, then ack -> err_underflow=1, free_cnt stays 0.
- clear_i mid-operation with FIFO={6,1}, fresh=5, errors set -> next cycle val=0, free_cnt=8, errs=0. Following cycle: addr=0, val=1.
